// File: rtl/control_unit3.sv
// Multicycle instruction-sequencing FSM for a simple datapath. Optional macro CTRL_ILLEGAL_TRAP_EN
// makes undefined opcodes halt with illegal=1; otherwise they retire as NOP.
module control_unit3 #(
  parameter logic [3:0] ALU_ADD = 4'h0,
  parameter logic [3:0] ALU_SUB = 4'h1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       DMEMWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       RegReadSel,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUSel,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
    S_WB_ALU = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WB = 4'd6, S_MEM_WR = 4'd7,
    S_WB_IMM = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_HALT  = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  logic is_rtype, is_imm_se, is_imm_ze, reads_rt;
  assign is_rtype  = (opcode[5:4] == 2'b01);
  assign is_imm_se = (opcode[5:4] == 2'b10);
  assign is_imm_ze = (opcode[5:4] == 2'b11) && (opcode[3:0] != 4'hF);
  assign reads_rt  = (opcode == 6'h02) || (opcode == 6'h03) ||
                     (opcode == 6'h04) || (opcode == 6'h05);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_rtype)                               state_d = S_EXEC_R;
        else if (is_imm_se || is_imm_ze)            state_d = S_EXEC_I;
        else if (opcode == 6'h01)                   state_d = S_MEM_RD;
        else if (opcode == 6'h02)                   state_d = S_MEM_WR;
        else if (opcode == 6'h03 || opcode == 6'h04) state_d = S_WB_IMM;
        else if (opcode == 6'h05)                   state_d = S_BRANCH;
        else if (opcode == 6'h06)                   state_d = S_JUMP;
        else if (opcode == 6'h0F)                   state_d = S_HALT;
        else if (opcode == 6'h00)                   state_d = S_FETCH;
        else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d   = S_HALT;
          illegal_d = 1'b1;
`else
          state_d   = S_FETCH;
`endif
        end
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_RD:           state_d = S_MEM_WB;
      S_HALT:             state_d = S_HALT;
      default:            state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Datapath controls decode from the current state plus the held opcode.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    DMEMWrite   = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    RegReadSel  = 1'b0;
    MemtoReg    = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUSel      = ALU_ADD;
    halted      = 1'b0;
    illegal     = 1'b0;
    if (state_q != S_FETCH && state_q != S_HALT) RegReadSel = reads_rt;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSel  = opcode[3:0];
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = is_imm_ze ? 2'b11 : 2'b10;
        ALUSel  = opcode[3:0];
      end
      S_WB_ALU: RegWrite = 1'b1;
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MEM_WR: DMEMWrite = 1'b1;
      S_WB_IMM: begin
        RegWrite = 1'b1;
        MemtoReg = (opcode == 6'h04) ? 2'b11 : 2'b10;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSel      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b10;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_HALT: begin
        halted  = 1'b1;
        illegal = illegal_q;
      end
      default: ;
    endcase
    // Reset overrides everything so no write can leak through mid-instruction.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      DMEMWrite   = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      RegReadSel  = 1'b0;
      MemtoReg    = 2'b00;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      ALUSel      = 4'h0;
      halted      = 1'b0;
      illegal     = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_unit3.sv
// Scoreboard bench for control_unit3: stimulus pushes hand-written per-cycle expectations,
// a negedge monitor pops and compares the full control vector.
module tb_control_unit3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA, RegReadSel;
  logic [1:0] MemtoReg, ALUSrcB, PCSource;
  logic [3:0] ALUSel, state;
  logic       halted, illegal;

  always #5 clk = ~clk;

  control_unit3 dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .DMEMWrite(DMEMWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .RegReadSel(RegReadSel), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUSel(ALUSel), .halted(halted), .illegal(illegal),
    .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, irw, dmw, rw, asa, rrs;
    logic [1:0] m2r, asb, pcs;
    logic [3:0] alu;
    logic       h, il;
  } vec_t;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, XR = 4'd2, XI = 4'd3, WA = 4'd4,
                         MR = 4'd5, MW = 4'd6, MX = 4'd7, WI = 4'd8, BR = 4'd9,
                         JP = 4'd10, HT = 4'd11;

  vec_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passes = 0;

  function automatic vec_t mk(logic [3:0] st, logic pcw, logic pcwc, logic irw,
                              logic dmw, logic rw, logic asa, logic rrs,
                              logic [1:0] m2r, logic [1:0] asb, logic [1:0] pcs,
                              logic [3:0] alu, logic h, logic il);
    vec_t v;
    v = '{st, pcw, pcwc, irw, dmw, rw, asa, rrs, m2r, asb, pcs, alu, h, il};
    return v;
  endfunction

  function automatic vec_t zeros(logic [3:0] st);
    return mk(st, 0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 4'h0, 0, 0);
  endfunction

  // Inputs for the cycle following the next rising edge, and what the DUT must show then.
  task automatic step(input logic rst, input logic [5:0] op, input vec_t e, input string nm);
    @(posedge clk);
    #1;
    reset  = rst;
    opcode = op;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t  e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{state, PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA,
             RegReadSel, MemtoReg, ALUSrcB, PCSource, ALUSel, halted, illegal};
      checks++;
      if (a === e) passes++;
      else $display("FAIL %s: got %h required %h", nm, a, e);
    end
  end

  vec_t F;
  initial begin
    F = mk(FE, 1,0,1,0,0,0,0, 2'd0, 2'd1, 2'd0, 4'h0, 0, 0);

    for (int i = 0; i < 3; i++) step(1, 6'h00, zeros(FE), "reset");
    step(0, 6'h00, F, "nop_fetch");
    step(0, 6'h00, zeros(DE), "nop_decode");

    step(0, 6'h12, F, "r_fetch");
    step(0, 6'h12, zeros(DE), "r_decode");
    step(0, 6'h12, mk(XR, 0,0,0,0,0,1,0, 2'd0, 2'd0, 2'd0, 4'h2, 0, 0), "r_exec");
    step(0, 6'h12, mk(WA, 0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd0, 4'h0, 0, 0), "r_wb");

    step(0, 6'h35, F, "ize_fetch");
    step(0, 6'h35, zeros(DE), "ize_decode");
    step(0, 6'h35, mk(XI, 0,0,0,0,0,1,0, 2'd0, 2'd3, 2'd0, 4'h5, 0, 0), "ize_exec");
    step(0, 6'h35, mk(WA, 0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd0, 4'h0, 0, 0), "ize_wb");

    step(0, 6'h2A, F, "ise_fetch");
    step(0, 6'h2A, zeros(DE), "ise_decode");
    step(0, 6'h2A, mk(XI, 0,0,0,0,0,1,0, 2'd0, 2'd2, 2'd0, 4'hA, 0, 0), "ise_exec");
    step(0, 6'h2A, mk(WA, 0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd0, 4'h0, 0, 0), "ise_wb");

    step(0, 6'h01, F, "lw_fetch");
    step(0, 6'h01, zeros(DE), "lw_decode");
    step(0, 6'h01, zeros(MR), "lw_memrd");
    step(0, 6'h01, mk(MW, 0,0,0,0,1,0,0, 2'd1, 2'd0, 2'd0, 4'h0, 0, 0), "lw_memwb");

    step(0, 6'h02, F, "sw_fetch");
    step(0, 6'h02, mk(DE, 0,0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 4'h0, 0, 0), "sw_decode");
    step(0, 6'h02, mk(MX, 0,0,0,1,0,0,1, 2'd0, 2'd0, 2'd0, 4'h0, 0, 0), "sw_memwr");

    step(0, 6'h05, F, "beq_fetch");
    step(0, 6'h05, mk(DE, 0,0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 4'h0, 0, 0), "beq_decode");
    step(0, 6'h05, mk(BR, 0,1,0,0,0,1,1, 2'd0, 2'd0, 2'd2, 4'h1, 0, 0), "beq_branch");

    step(0, 6'h04, F, "lui_fetch");
    step(0, 6'h04, mk(DE, 0,0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 4'h0, 0, 0), "lui_decode");
    step(0, 6'h04, mk(WI, 0,0,0,0,1,0,1, 2'd3, 2'd0, 2'd0, 4'h0, 0, 0), "lui_wbimm");

    step(0, 6'h03, F, "lli_fetch");
    step(0, 6'h03, mk(DE, 0,0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 4'h0, 0, 0), "lli_decode");
    step(0, 6'h03, mk(WI, 0,0,0,0,1,0,1, 2'd2, 2'd0, 2'd0, 4'h0, 0, 0), "lli_wbimm");

    step(0, 6'h06, F, "jmp_fetch");
    step(0, 6'h06, zeros(DE), "jmp_decode");
    step(0, 6'h06, mk(JP, 1,0,0,0,0,0,0, 2'd0, 2'd0, 2'd2, 4'h0, 0, 0), "jmp_jump");

    step(0, 6'h0F, F, "halt_fetch");
    step(0, 6'h0F, zeros(DE), "halt_decode");
    for (int i = 0; i < 10; i++)
      step(0, 6'h0F, mk(HT, 0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 4'h0, 1, 0), "halt_hold");
    step(1, 6'h00, zeros(HT), "halt_reset");
    step(0, 6'h3F, F, "halt_exit_fetch");

    step(0, 6'h3F, zeros(DE), "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      step(0, 6'h3F, mk(HT, 0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 4'h0, 1, 1), "ill_trap");
    step(1, 6'h00, zeros(HT), "ill_reset");
    step(0, 6'h12, F, "ill_exit_fetch");
`else
    step(0, 6'h12, F, "ill_as_nop_fetch");
`endif

    step(0, 6'h12, zeros(DE), "rst_mid_decode");
    step(1, 6'h12, zeros(XR), "rst_mid_exec");
    step(0, 6'h00, F, "rst_mid_fetch");
    step(0, 6'h00, zeros(DE), "post_nop_decode");
    step(0, 6'h00, F, "post_nop_fetch");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_unit3.md
CONTROL_UNIT3 -- requirements
Module: control_unit3

Interface
REQ-001 Parameter ALU_ADD, default 4'h0, ALUSel code for add.
REQ-002 Parameter ALU_SUB, default 4'h1, ALUSel code for subtract.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 opcode  input  6  IR[31:26] from datapath.
REQ-006 PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA, RegReadSel  output  1 each  datapath controls.
REQ-007 MemtoReg, ALUSrcB, PCSource  output  2 each  datapath mux selects.
REQ-008 ALUSel  output  4  ALU function.
REQ-009 halted  output  1  high while in HALT.
REQ-010 illegal  output  1  high while halted on undefined opcode.
REQ-011 state  output  4  current state encoding, for debug.

Function
REQ-012 Opcode map: 00 NOP; 01 LW; 02 SW; 03 LLI; 04 LUI; 05 BEQ; 06 JMP; 0F HALT; 10-1F R-type; 20-2F imm-SE; 30-3E imm-ZE; all others undefined.
REQ-013 States: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_RD, MEM_WB, MEM_WR, WB_IMM, BRANCH, JUMP, HALT; outputs decoded from state and opcode (Moore + opcode).
REQ-014 Unlisted outputs in any state are 0; ALUSel defaults ALU_ADD.
REQ-015 FETCH: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUSel=ALU_ADD, PCSource=00; -> DECODE.
REQ-016 DECODE: no writes; RegReadSel=1 for SW, LLI, LUI, BEQ, else 0; next: R-type->EXEC_R, imm->EXEC_I, LW->MEM_RD, SW->MEM_WR, LLI/LUI->WB_IMM, BEQ->BRANCH, JMP->JUMP, HALT->HALT, NOP->FETCH.
REQ-017 RegReadSel holds its DECODE value through all states of the instruction.
REQ-018 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUSel=opcode[3:0]; -> WB_ALU.
REQ-019 EXEC_I: ALUSrcA=1, ALUSrcB=10 for 20-2F, 11 for 30-3E, ALUSel=opcode[3:0]; -> WB_ALU.
REQ-020 WB_ALU: RegWrite=1, MemtoReg=00; -> FETCH.
REQ-021 MEM_RD: no writes; -> MEM_WB. MEM_WB: RegWrite=1, MemtoReg=01; -> FETCH.
REQ-022 MEM_WR: DMEMWrite=1; -> FETCH.
REQ-023 WB_IMM: RegWrite=1, MemtoReg=10 for LLI, 11 for LUI; -> FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUSel=ALU_SUB, PCWriteCond=1, PCSource=10; -> FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10; -> FETCH.
REQ-026 HALT: all enables 0, halted=1; remains until reset.
REQ-027 Latency in cycles: NOP 2; SW, LLI, LUI, BEQ, JMP 3; R-type, imm, LW 4.
REQ-028 IRWrite asserted only in FETCH; opcode treated as stable from DECODE to next FETCH.

Reset
REQ-029 reset high at a rising edge: state <= FETCH, illegal/halted cleared; takes priority over every transition, including HALT and mid-instruction states.
REQ-030 While reset is high, all write-enable outputs (PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite) are forced 0 combinationally; selects 0, halted=0, illegal=0.
REQ-031 First cycle after reset deassertion is FETCH.

Configuration
REQ-032 Macro CTRL_ILLEGAL_TRAP_EN defined: undefined opcode in DECODE -> HALT with illegal=1.
REQ-033 Macro undefined: undefined opcode treated as NOP (DECODE -> FETCH); illegal tied 0.

Verification
REQ-034 Reset 3 cycles, then opcode 00 -> state sequence FETCH, DECODE, FETCH; IRWrite=1 and PCWrite=1 only in FETCH.
REQ-035 opcode 6'h12 -> FETCH, DECODE, EXEC_R (ALUSel=4'h2, ALUSrcA=1, ALUSrcB=00), WB_ALU (RegWrite=1, MemtoReg=00).
REQ-036 opcode 6'h01 -> MEM_RD then MEM_WB with MemtoReg=01, RegWrite=1; opcode 6'h02 -> MEM_WR with DMEMWrite=1, RegReadSel=1 from DECODE on.
REQ-037 opcode 6'h05 -> BRANCH: PCWriteCond=1, PCSource=10, ALUSel=4'h1, PCWrite=0; 6'h04 -> WB_IMM MemtoReg=11.
REQ-038 opcode 6'h0F -> HALT, halted=1 for 10 cycles; reset -> FETCH, halted=0.
REQ-039 opcode 6'h3F -> with CTRL_ILLEGAL_TRAP_EN: HALT, illegal=1; without: back to FETCH, illegal=0; reset asserted during EXEC_R -> FETCH next cycle, RegWrite never pulses.
